// File: rtl/clock_pkg.sv
// Shared state encoding and BCD limits for the clock setting controller.
package clock_pkg;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_SET_HOUR = 3'd1,
        ST_SET_MIN  = 3'd2,
        ST_SET_SEC  = 3'd3,
        ST_ALM_HOUR = 3'd4,
        ST_ALM_MIN  = 3'd5
    } state_e;

    localparam logic [6:0] HOUR_MAX   = 7'd23;
    localparam logic [6:0] MINSEC_MAX = 7'd59;

    // Editable fields: 0 hour, 1 min, 2 sec, 3 alarm hour, 4 alarm min.
    localparam int NUM_FIELDS = 5;

    function automatic logic [2:0] field_of(input state_e s);
        return 3'(s) - 3'd1;
    endfunction

endpackage

// File: rtl/set_ctrl_bcd_pair_step.sv
// One-step increment/decrement of a two-digit BCD value with wrap at 0 and max.
module bcd_pair_step
    import clock_pkg::*;
(
    input  logic [3:0] tens_i,
    input  logic [3:0] ones_i,
    input  logic [6:0] max_i,
    input  logic       up_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o
);

    logic [6:0] val;
    logic [6:0] nxt;

    always_comb begin
        val = {3'b000, tens_i} * 7'd10 + {3'b000, ones_i};
        if (up_i) begin
            nxt = (val >= max_i) ? 7'd0 : val + 7'd1;
        end else begin
            // Out-of-range values fall back to max so the result is always legal.
            nxt = (val == 7'd0 || val > max_i) ? max_i : val - 7'd1;
        end
        tens_o = 4'(nxt / 7'd10);
        ones_o = 4'(nxt % 7'd10);
    end

endmodule

// File: rtl/set_ctrl.sv
// Time/alarm setting controller: mode-driven edit FSM, BCD field stepping,
// load strobe to the timekeeper and a blink phase for the edited field.
module set_ctrl
    import clock_pkg::*;
#(
    parameter int BLINK_HALF = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_cancel,
    input  logic       btn_alarm,
    input  logic [3:0] cur_sec_ge,
    input  logic [3:0] cur_sec_shi,
    input  logic [3:0] cur_min_ge,
    input  logic [3:0] cur_min_shi,
    input  logic [3:0] cur_hour_ge,
    input  logic [3:0] cur_hour_shi,
    output logic [3:0] set_sec_ge,
    output logic [3:0] set_sec_shi,
    output logic [3:0] set_min_ge,
    output logic [3:0] set_min_shi,
    output logic [3:0] set_hour_ge,
    output logic [3:0] set_hour_shi,
    output logic       set_time_finish,
    output logic       clock_en,
    output logic [3:0] clock_min_ge,
    output logic [3:0] clock_min_shi,
    output logic [3:0] clock_hour_ge,
    output logic [3:0] clock_hour_shi,
    output logic [2:0] edit_field,
    output logic       blink_on
);

    localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    state_e                         state_q, state_d;
    logic [NUM_FIELDS-1:0][3:0]     tens_q, ones_q;
    logic [NUM_FIELDS-1:0][3:0]     step_tens, step_ones;
    logic [NUM_FIELDS-1:0]          step_en;
    logic                           step_up;
    logic                           load;
    logic                           finish_q, finish_d;
    logic                           en_q, en_d;
    logic [CW-1:0]                  cnt_q;
    logic                           phase_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FIELDS; gi++) begin : g_step
            bcd_pair_step u_step (
                .tens_i (tens_q[gi]),
                .ones_i (ones_q[gi]),
                .max_i  ((gi == 0 || gi == 3) ? HOUR_MAX : MINSEC_MAX),
                .up_i   (step_up),
                .tens_o (step_tens[gi]),
                .ones_o (step_ones[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        finish_d = 1'b0;
        load     = 1'b0;
        step_en  = '0;
        step_up  = 1'b0;
        en_d     = en_q ^ btn_alarm;
        if (state_q == ST_RUN) begin
            if (btn_mode) begin
                state_d = ST_SET_HOUR;
                load    = 1'b1;
            end
        end else if (btn_cancel) begin
            state_d = ST_RUN;
        end else if (btn_mode) begin
            case (state_q)
                ST_SET_HOUR: state_d = ST_SET_MIN;
                ST_SET_MIN:  state_d = ST_SET_SEC;
                ST_SET_SEC: begin
                    state_d  = ST_ALM_HOUR;
                    finish_d = 1'b1;
                end
                ST_ALM_HOUR: state_d = ST_ALM_MIN;
                default:     state_d = ST_RUN;
            endcase
        end else if (btn_inc || btn_dec) begin
            step_en[field_of(state_q)] = 1'b1;
            step_up                    = btn_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            tens_q   <= '0;
            ones_q   <= '0;
            finish_q <= 1'b0;
            en_q     <= 1'b0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            finish_q <= finish_d;
            en_q     <= en_d;
            if (load) begin
                tens_q[0] <= cur_hour_shi;
                ones_q[0] <= cur_hour_ge;
                tens_q[1] <= cur_min_shi;
                ones_q[1] <= cur_min_ge;
                tens_q[2] <= cur_sec_shi;
                ones_q[2] <= cur_sec_ge;
            end else begin
                for (int i = 0; i < NUM_FIELDS; i++) begin
                    if (step_en[i]) begin
                        tens_q[i] <= step_tens[i];
                        ones_q[i] <= step_ones[i];
                    end
                end
            end
            // Restart the blink on every transition so the new field shows at once.
            if (state_d != state_q) begin
                cnt_q   <= '0;
                phase_q <= 1'b0;
            end else if (cnt_q == CW'(BLINK_HALF - 1)) begin
                cnt_q   <= '0;
                phase_q <= ~phase_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign set_hour_shi    = tens_q[0];
    assign set_hour_ge     = ones_q[0];
    assign set_min_shi     = tens_q[1];
    assign set_min_ge      = ones_q[1];
    assign set_sec_shi     = tens_q[2];
    assign set_sec_ge      = ones_q[2];
    assign clock_hour_shi  = tens_q[3];
    assign clock_hour_ge   = ones_q[3];
    assign clock_min_shi   = tens_q[4];
    assign clock_min_ge    = ones_q[4];
    assign set_time_finish = finish_q;
    assign clock_en        = en_q;
    assign edit_field      = state_q;
    assign blink_on        = phase_q & (state_q != ST_RUN);

endmodule

// File: tb/tb_set_ctrl.sv
// Randomized and directed checks of set_ctrl against an integer-level model
// of the edit/alarm behaviour.
module tb_set_ctrl;

    logic       clk = 1'b0;
    logic       rst, btn_mode, btn_inc, btn_dec, btn_cancel, btn_alarm;
    logic [3:0] cur_sec_ge, cur_sec_shi, cur_min_ge, cur_min_shi, cur_hour_ge, cur_hour_shi;
    logic [3:0] set_sec_ge, set_sec_shi, set_min_ge, set_min_shi, set_hour_ge, set_hour_shi;
    logic       set_time_finish, clock_en, blink_on;
    logic [3:0] clock_min_ge, clock_min_shi, clock_hour_ge, clock_hour_shi;
    logic [2:0] edit_field;

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc   = 0;

    // Model: state code, values {hour,min,sec,alarm hour,alarm min}, enable,
    // expected strobe, cycles since last state change.
    int m_st, m_en, m_fin, m_n;
    int m_val[5];
    int cur_h, cur_m, cur_s;

    set_ctrl #(.BLINK_HALF(4)) dut (
        .clk(clk), .rst(rst),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .btn_cancel(btn_cancel), .btn_alarm(btn_alarm),
        .cur_sec_ge(cur_sec_ge), .cur_sec_shi(cur_sec_shi),
        .cur_min_ge(cur_min_ge), .cur_min_shi(cur_min_shi),
        .cur_hour_ge(cur_hour_ge), .cur_hour_shi(cur_hour_shi),
        .set_sec_ge(set_sec_ge), .set_sec_shi(set_sec_shi),
        .set_min_ge(set_min_ge), .set_min_shi(set_min_shi),
        .set_hour_ge(set_hour_ge), .set_hour_shi(set_hour_shi),
        .set_time_finish(set_time_finish), .clock_en(clock_en),
        .clock_min_ge(clock_min_ge), .clock_min_shi(clock_min_shi),
        .clock_hour_ge(clock_hour_ge), .clock_hour_shi(clock_hour_shi),
        .edit_field(edit_field), .blink_on(blink_on)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int fmax(input int f);
        return (f == 0 || f == 3) ? 23 : 59;
    endfunction

    task automatic cycle(input logic r, input logic md, input logic ic,
                         input logic dc, input logic cn, input logic al);
        int nst;
        @(negedge clk);
        rst = r; btn_mode = md; btn_inc = ic; btn_dec = dc; btn_cancel = cn; btn_alarm = al;
        {cur_hour_shi, cur_hour_ge} = bcd2(cur_h);
        {cur_min_shi, cur_min_ge}   = bcd2(cur_m);
        {cur_sec_shi, cur_sec_ge}   = bcd2(cur_s);
        if (r) begin
            m_st = 0; m_en = 0; m_fin = 0; m_n = 0;
            for (int i = 0; i < 5; i++) m_val[i] = 0;
        end else begin
            nst   = m_st;
            m_fin = 0;
            if (al) m_en = 1 - m_en;
            if (m_st == 0) begin
                if (md) begin
                    nst = 1; m_val[0] = cur_h; m_val[1] = cur_m; m_val[2] = cur_s;
                end
            end else if (cn) begin
                nst = 0;
            end else if (md) begin
                nst = (m_st == 5) ? 0 : m_st + 1;
                if (m_st == 3) m_fin = 1;
            end else if (ic) begin
                m_val[m_st-1] = (m_val[m_st-1] + 1) % (fmax(m_st-1) + 1);
            end else if (dc) begin
                m_val[m_st-1] = (m_val[m_st-1] + fmax(m_st-1)) % (fmax(m_st-1) + 1);
            end
            m_n  = (nst != m_st) ? 0 : m_n + 1;
            m_st = nst;
        end
        @(posedge clk);
        #1;
        n_cyc++;
        check("state", 32'(edit_field), 32'(m_st));
        check("set_time", {8'h0, set_hour_shi, set_hour_ge, set_min_shi, set_min_ge, set_sec_shi, set_sec_ge},
              {8'h0, bcd2(m_val[0]), bcd2(m_val[1]), bcd2(m_val[2])});
        check("alarm", {16'h0, clock_hour_shi, clock_hour_ge, clock_min_shi, clock_min_ge},
              {16'h0, bcd2(m_val[3]), bcd2(m_val[4])});
        check("clock_en", 32'(clock_en), 32'(m_en));
        check("finish", 32'(set_time_finish), 32'(m_fin));
        check("blink", 32'(blink_on), 32'((m_st != 0) && (((m_n / 4) % 2) == 1)));
        $display("[TB] cyc %0d r=%b m=%b i=%b d=%b c=%b a=%b -> st=%0d set=%0h%0h:%0h%0h:%0h%0h alm=%0h%0h:%0h%0h en=%b fin=%b blink=%b",
                 n_cyc, r, md, ic, dc, cn, al, edit_field, set_hour_shi, set_hour_ge, set_min_shi, set_min_ge,
                 set_sec_shi, set_sec_ge, clock_hour_shi, clock_hour_ge, clock_min_shi, clock_min_ge,
                 clock_en, set_time_finish, blink_on);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        cur_h = 12; cur_m = 34; cur_s = 56;
        m_st = 0; m_en = 0; m_fin = 0; m_n = 0;
        for (int i = 0; i < 5; i++) m_val[i] = 0;
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 1, 1, 0, 0, 1);
        check("reset_state", 32'(edit_field), 32'd0);

        // Basic set flow: one strobe with 13:34:56, then ALM_HOUR.
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        check("flow_fin_pre", 32'(set_time_finish), 32'd0);
        cycle(0, 1, 0, 0, 0, 0);
        check("flow_fin", 32'(set_time_finish), 32'd1);
        check("flow_set", {set_hour_shi, set_hour_ge, set_min_shi, set_min_ge, set_sec_shi, set_sec_ge}, 24'h133456);
        check("flow_state", 32'(edit_field), 32'd4);
        cycle(0, 0, 0, 0, 1, 0);

        // Wrap boundaries.
        cur_h = 23; cur_m = 0; cur_s = 59;
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        check("hour_wrap_up", {set_hour_shi, set_hour_ge}, 8'h00);
        cycle(0, 0, 0, 1, 0, 0);
        check("hour_wrap_dn", {set_hour_shi, set_hour_ge}, 8'h23);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        check("min_wrap_dn", {set_min_shi, set_min_ge}, 8'h59);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        check("sec_wrap_up", {set_sec_shi, set_sec_ge}, 8'h00);
        cycle(0, 0, 0, 0, 1, 0);
        check("cancel_nofin", 32'(set_time_finish), 32'd0);

        // Priority: mode over inc, cancel over mode.
        cur_h = 8; cur_m = 15; cur_s = 0;
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 0);
        check("prio_min", {set_min_shi, set_min_ge}, 8'h15);
        check("prio_state", 32'(edit_field), 32'd3);
        cycle(0, 1, 0, 0, 1, 0);
        check("prio_cancel", 32'(edit_field), 32'd0);
        check("prio_nofin", 32'(set_time_finish), 32'd0);

        // Alarm set to 07:30 and enable.
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 30; i++) cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        check("alarm_val", {clock_hour_shi, clock_hour_ge, clock_min_shi, clock_min_ge}, 16'h0730);
        check("alarm_state", 32'(edit_field), 32'd0);
        cycle(0, 0, 0, 0, 0, 1);
        check("alarm_en", 32'(clock_en), 32'd1);

        // Reset mid-edit.
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        check("rst_state", 32'(edit_field), 32'd0);
        check("rst_fin", 32'(set_time_finish), 32'd0);
        check("rst_en", 32'(clock_en), 32'd0);
        cycle(0, 0, 0, 0, 0, 0);
        check("rst_fin_after", 32'(set_time_finish), 32'd0);

        // Blink phase with BLINK_HALF = 4.
        cycle(0, 1, 0, 0, 0, 0);
        check("blink_start", 32'(blink_on), 32'd0);
        idle(4);
        check("blink_toggle", 32'(blink_on), 32'd1);
        idle(3);
        cycle(0, 1, 0, 0, 0, 0);
        check("blink_restart", 32'(blink_on), 32'd0);
        cycle(0, 0, 0, 0, 1, 0);

        // Randomized traffic, with the running time moving underneath.
        for (int it = 0; it < 400; it++) begin
            cur_h = $urandom_range(23);
            cur_m = $urandom_range(59);
            cur_s = $urandom_range(59);
            cycle(($urandom_range(63) == 0), ($urandom_range(7) == 0), ($urandom_range(3) == 0),
                  ($urandom_range(3) == 0), ($urandom_range(15) == 0), ($urandom_range(15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
